// File: rtl/ustc_pkg.sv
// ustc_pkg: shared constants and helpers for the DN feeder slice.
//   - Default geometry of the sparse distribution network.
//   - Width-derivation functions used to size lines and the idx bus.
//   - Range check applied to every crossbar select index.
package ustc_pkg;

  localparam int NUM_XBAR_DEF     = 4;
  localparam int N_XBAR_IN_DEF    = 8;
  localparam int DW_DATA_DEF      = 32;
  localparam int DW_IDX_DEF       = 4;
  localparam int NUM_PER_LINE_DEF = 1;
  localparam int TILE_BEATS_DEF   = 4;
  localparam int DW_TILE_DEF      = 16;

  // Width of one dense line.
  function automatic int dn_line_w(input int dw_data, input int num_per_line);
    return dw_data * num_per_line;
  endfunction

  // Total number of DN outputs, which is also the number of idx fields.
  function automatic int dn_out_n(input int num_xbar, input int n_xbar_in);
    return num_xbar * n_xbar_in;
  endfunction

  // A select index is usable only if it addresses an existing crossbar input.
  function automatic logic idx_in_range(input int field, input int n_xbar_in);
    return (field < n_xbar_in);
  endfunction

endpackage

// File: rtl/ustc_fifo2.sv
// ustc_fifo2: generic 2-entry valid/ready FIFO with synchronous clear.
//   clk, reset (async, active-low), clear (sync flush, beats of that cycle dropped)
//   in_valid/in_ready/in_data   : write side; in_ready depends only on occupancy
//   out_valid/out_ready/out_data: read side; out_data is the head entry
// No bypass path: a beat written at edge t becomes visible the cycle after t.
module ustc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];

  // clear wins over both handshakes in the same cycle.
  assign push = in_valid & in_ready & ~clear;
  assign pop  = out_valid & out_ready & ~clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is zeroed on reset so the presented payload reads 0 when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/ustc_dn_feeder.sv
// ustc_dn_feeder: staging stage in front of the sparse distribution network.
//   clk, reset (async, active-low), clear (sync flush of FIFO, counters, idx_err)
//   s_valid/s_ready/s_data/s_idx : beats from the operand fetch path
//   m_valid/m_ready/m_data/m_idx : head beat presented to the DN (idx sanitised)
//   m_last   : presented beat closes the current tile
//   tile_cnt : completed tiles, wrapping
//   idx_err  : sticky flag, an accepted beat carried an out-of-range index
// DW_IDX must satisfy 2**DW_IDX >= N_XBAR_IN.
module ustc_dn_feeder
  import ustc_pkg::*;
#(
  parameter int NUM_XBAR     = NUM_XBAR_DEF,
  parameter int N_XBAR_IN    = N_XBAR_IN_DEF,
  parameter int N_DN_IN      = dn_out_n(NUM_XBAR, N_XBAR_IN),
  parameter int DW_DATA      = DW_DATA_DEF,
  parameter int DW_IDX       = DW_IDX_DEF,
  parameter int NUM_PER_LINE = NUM_PER_LINE_DEF,
  parameter int DW_LINE      = dn_line_w(DW_DATA, NUM_PER_LINE),
  parameter int TILE_BEATS   = TILE_BEATS_DEF,
  parameter int DW_TILE      = DW_TILE_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [N_XBAR_IN*DW_LINE-1:0] s_data,
  input  logic [N_DN_IN*DW_IDX-1:0]    s_idx,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [N_XBAR_IN*DW_LINE-1:0] m_data,
  output logic [N_DN_IN*DW_IDX-1:0]    m_idx,
  output logic                         m_last,
  output logic [DW_TILE-1:0]           tile_cnt,
  output logic                         idx_err
);

  localparam int DW_D = N_XBAR_IN * DW_LINE;
  localparam int DW_I = N_DN_IN * DW_IDX;
  localparam int BW   = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(TILE_BEATS - 1);

  logic [DW_I-1:0]      idx_san;
  logic                 idx_bad;
  logic                 accept;
  logic                 pop;
  logic [BW-1:0]        beat_cnt;
  logic [DW_D+DW_I-1:0] fifo_out;

  // Out-of-range fields are replaced by 0 before they are stored, so the DN
  // never sees an index that addresses a missing crossbar input.
  always_comb begin
    idx_san = '0;
    idx_bad = 1'b0;
    for (int j = 0; j < N_DN_IN; j++) begin
      if (idx_in_range(int'(s_idx[j*DW_IDX +: DW_IDX]), N_XBAR_IN))
        idx_san[j*DW_IDX +: DW_IDX] = s_idx[j*DW_IDX +: DW_IDX];
      else
        idx_bad = 1'b1;
    end
  end

  ustc_fifo2 #(
    .W (DW_D + DW_I)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   ({s_data, idx_san}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (fifo_out)
  );

  assign m_data = fifo_out[DW_I +: DW_D];
  assign m_idx  = fifo_out[0 +: DW_I];
  assign m_last = m_valid & (beat_cnt == BEAT_LAST);

  assign accept = s_valid & s_ready & ~clear;
  assign pop    = m_valid & m_ready & ~clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      tile_cnt <= '0;
      idx_err  <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      tile_cnt <= '0;
      idx_err  <= 1'b0;
    end else begin
      if (pop) beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BW'(1);
      if (pop && m_last) tile_cnt <= tile_cnt + DW_TILE'(1);
      if (accept && idx_bad) idx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ustc_dn_feeder.sv
// Directed bench for ustc_dn_feeder with default parameters.
module tb_ustc_dn_feeder;

  typedef logic [511:0] cw_t;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_data;
  logic [127:0] s_idx;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_data;
  logic [127:0] m_idx;
  logic         m_last;
  logic [15:0]  tile_cnt;
  logic         idx_err;

  int checks = 0;
  int errors = 0;

  ustc_dn_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_idx    (s_idx),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_idx    (m_idx),
    .m_last   (m_last),
    .tile_cnt (tile_cnt),
    .idx_err  (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mk_data(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [127:0] mk_idx();
    logic [127:0] r;
    for (int j = 0; j < 32; j++) r[j*4 +: 4] = 4'(j % 8);
    return r;
  endfunction

  task automatic chk(input string tag, input cw_t obs, input cw_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n beats back to back with m_ready=1; bc0 is the beat count
  // expected when the first beat is presented.
  task automatic stream(input int n, input int bc0, input logic [31:0] base);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_idx   = mk_idx();
    s_data  = mk_data(base);
    for (int i = 1; i <= n; i++) begin
      step();
      chk("stream_valid", cw_t'(m_valid), cw_t'(1'b1));
      chk("stream_data", cw_t'(m_data), cw_t'(mk_data(base + 32'((i - 1) * 16))));
      chk("stream_last", cw_t'(m_last), cw_t'(((bc0 + i - 1) % 4) == 3));
      chk("stream_ready", cw_t'(s_ready), cw_t'(1'b1));
      if (i < n) s_data = mk_data(base + 32'(i * 16));
      else s_valid = 1'b0;
    end
    step();
    chk("stream_drain", cw_t'(m_valid), cw_t'(1'b0));
    m_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] bad_idx;
    logic [127:0] san_idx;

    reset   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_idx   = '0;
    m_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_m_valid", cw_t'(m_valid), cw_t'(1'b0));
    chk("rst_s_ready", cw_t'(s_ready), cw_t'(1'b1));
    chk("rst_m_last", cw_t'(m_last), cw_t'(1'b0));
    chk("rst_tile", cw_t'(tile_cnt), cw_t'(16'd0));
    chk("rst_idx_err", cw_t'(idx_err), cw_t'(1'b0));
    chk("rst_m_data", cw_t'(m_data), cw_t'(256'd0));
    chk("rst_m_idx", cw_t'(m_idx), cw_t'(128'd0));
    reset = 1'b1;
    step();

    // 1: single beat, one-cycle latency
    s_valid = 1'b1;
    s_data  = mk_data(32'h100);
    s_idx   = mk_idx();
    chk("t1_ready_before", cw_t'(s_ready), cw_t'(1'b1));
    step();
    s_valid = 1'b0;
    chk("t1_valid", cw_t'(m_valid), cw_t'(1'b1));
    chk("t1_data", cw_t'(m_data), cw_t'(mk_data(32'h100)));
    chk("t1_idx", cw_t'(m_idx), cw_t'(mk_idx()));
    chk("t1_last", cw_t'(m_last), cw_t'(1'b0));
    chk("t1_ready", cw_t'(s_ready), cw_t'(1'b1));
    m_ready = 1'b1;
    step();
    chk("t1_popped", cw_t'(m_valid), cw_t'(1'b0));
    m_ready = 1'b0;

    // 2: backpressure with A, B, C (beat count now 1)
    s_valid = 1'b1;
    s_data  = mk_data(32'hA00);
    step();
    chk("t2_ready_occ1", cw_t'(s_ready), cw_t'(1'b1));
    s_data = mk_data(32'hB00);
    step();
    chk("t2_ready_full", cw_t'(s_ready), cw_t'(1'b0));
    chk("t2_head_A", cw_t'(m_data), cw_t'(mk_data(32'hA00)));
    s_data = mk_data(32'hC00);
    step();
    chk("t2_held_ready", cw_t'(s_ready), cw_t'(1'b0));
    chk("t2_stable_A", cw_t'(m_data), cw_t'(mk_data(32'hA00)));
    m_ready = 1'b1;
    step();
    chk("t2_head_B", cw_t'(m_data), cw_t'(mk_data(32'hB00)));
    chk("t2_B_last", cw_t'(m_last), cw_t'(1'b0));
    chk("t2_ready_occ1b", cw_t'(s_ready), cw_t'(1'b1));
    step();
    s_valid = 1'b0;
    chk("t2_head_C", cw_t'(m_data), cw_t'(mk_data(32'hC00)));
    chk("t2_C_last", cw_t'(m_last), cw_t'(1'b1));
    step();
    chk("t2_empty", cw_t'(m_valid), cw_t'(1'b0));
    chk("t2_tile", cw_t'(tile_cnt), cw_t'(16'd1));
    m_ready = 1'b0;

    // 3: streaming 8 beats
    stream(8, 0, 32'h3000);
    chk("t3_tile", cw_t'(tile_cnt), cw_t'(16'd3));

    // 4: out-of-range indices are zeroed, idx_err sticky
    bad_idx = mk_idx();
    bad_idx[5*4 +: 4]  = 4'd9;
    bad_idx[31*4 +: 4] = 4'd15;
    san_idx = mk_idx();
    san_idx[5*4 +: 4]  = 4'd0;
    san_idx[31*4 +: 4] = 4'd0;
    chk("t4_err_before", cw_t'(idx_err), cw_t'(1'b0));
    s_valid = 1'b1;
    s_data  = mk_data(32'h400);
    s_idx   = bad_idx;
    step();
    s_valid = 1'b0;
    s_idx   = mk_idx();
    chk("t4_m_idx", cw_t'(m_idx), cw_t'(san_idx));
    chk("t4_err_set", cw_t'(idx_err), cw_t'(1'b1));
    repeat (10) step();
    chk("t4_err_sticky", cw_t'(idx_err), cw_t'(1'b1));
    chk("t4_idx_stable", cw_t'(m_idx), cw_t'(san_idx));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;

    // 5: clear with occupancy 2, beat count 2
    s_valid = 1'b1;
    s_data  = mk_data(32'h500);
    step();
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = mk_data(32'hE00);
    step();
    s_data = mk_data(32'hF00);
    step();
    chk("t5_full", cw_t'(s_ready), cw_t'(1'b0));
    chk("t5_head_E", cw_t'(m_data), cw_t'(mk_data(32'hE00)));
    s_data  = mk_data(32'h600);
    clear   = 1'b1;
    m_ready = 1'b1;
    step();
    clear   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("t5_valid", cw_t'(m_valid), cw_t'(1'b0));
    chk("t5_tile", cw_t'(tile_cnt), cw_t'(16'd0));
    chk("t5_err", cw_t'(idx_err), cw_t'(1'b0));
    chk("t5_ready", cw_t'(s_ready), cw_t'(1'b1));
    step();
    chk("t5_no_deliver", cw_t'(m_valid), cw_t'(1'b0));
    // clear with room in the FIFO also drops the incoming beat
    s_valid = 1'b1;
    s_data  = mk_data(32'h700);
    step();
    s_data = mk_data(32'h800);
    clear  = 1'b1;
    step();
    clear   = 1'b0;
    s_valid = 1'b0;
    chk("t5b_valid", cw_t'(m_valid), cw_t'(1'b0));
    step();
    chk("t5b_no_deliver", cw_t'(m_valid), cw_t'(1'b0));
    // beat count restarted at 0: m_last on the 4th beat only
    stream(4, 0, 32'h9000);
    chk("t5_tile_after", cw_t'(tile_cnt), cw_t'(16'd1));

    // 6: asynchronous reset while a last-of-tile beat is presented
    stream(3, 0, 32'hA000);
    s_valid = 1'b1;
    s_data  = mk_data(32'hB000);
    s_idx   = bad_idx;
    step();
    s_valid = 1'b0;
    chk("t6_valid", cw_t'(m_valid), cw_t'(1'b1));
    chk("t6_last", cw_t'(m_last), cw_t'(1'b1));
    chk("t6_err", cw_t'(idx_err), cw_t'(1'b1));
    chk("t6_tile", cw_t'(tile_cnt), cw_t'(16'd1));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", cw_t'(m_valid), cw_t'(1'b0));
    chk("t6_rst_last", cw_t'(m_last), cw_t'(1'b0));
    chk("t6_rst_tile", cw_t'(tile_cnt), cw_t'(16'd0));
    chk("t6_rst_err", cw_t'(idx_err), cw_t'(1'b0));
    chk("t6_rst_ready", cw_t'(s_ready), cw_t'(1'b1));
    chk("t6_rst_data", cw_t'(m_data), cw_t'(256'd0));
    step();
    reset = 1'b1;
    step();
    chk("t6_after_valid", cw_t'(m_valid), cw_t'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
